q_dot_acc: RTL

- Streaming fixed-point dot-product accumulator; the stage directly downstream of the single-cycle Q-format multiplier qMult_sc.
- Accepts operand pairs with valid/ready and a last flag, multiplies each pair through one qMult_sc instance, and registers the product.
- Accumulates products in a guard-extended accumulator and emits one saturated Q(INTEGER_BITS).(FRACTIONAL_BITS) result per vector on a valid/ready output.

---
 rtl/q_fixed_pkg.sv | 22 ++
 rtl/qMult_sc.sv | 24 ++
 rtl/q_dot_acc.sv | 137 +++++++++++++
 3 files changed

// File: rtl/q_fixed_pkg.sv
// Shared Q-format defaults, constants and state encoding for the
// fixed-point dot-product datapath.
package q_fixed_pkg;

  localparam int DEF_INTEGER_BITS    = 8;
  localparam int DEF_FRACTIONAL_BITS = 24;
  localparam int DEF_DATA_WIDTH      = DEF_INTEGER_BITS + DEF_FRACTIONAL_BITS;

  // 1.0, largest and most negative representable Q values
  localparam logic signed [DEF_DATA_WIDTH-1:0] Q_ONE =
    {{(DEF_INTEGER_BITS-1){1'b0}}, 1'b1, {DEF_FRACTIONAL_BITS{1'b0}}};
  localparam logic signed [DEF_DATA_WIDTH-1:0] Q_MAX =
    {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_DATA_WIDTH-1:0] Q_MIN =
    {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_e;

endpackage

// File: rtl/qMult_sc.sv
// Single-cycle Q-format multiplier: round-to-nearest on the dropped
// fractional bits, wraps when the product exceeds the Q range.
module qMult_sc #(
  parameter int FRACTIONAL_BITS = 24,
  parameter int DATA_WIDTH      = 32
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] q_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRACTIONAL_BITS - 1);

  logic signed [PW-1:0] prod_full;

  // Full-precision product plus half an output LSB
  always_comb begin
    prod_full = PW'(a_i) * PW'(b_i) + RND;
  end

  assign q_o = DATA_WIDTH'(prod_full >>> FRACTIONAL_BITS);

endmodule

// File: rtl/q_dot_acc.sv
// Streaming fixed-point dot-product accumulator. Each accepted operand
// pair is multiplied, registered, and summed into a guard-extended
// accumulator; the last beat of a vector produces one saturated result.
module q_dot_acc
  import q_fixed_pkg::*;
#(
  parameter int INTEGER_BITS    = DEF_INTEGER_BITS,
  parameter int FRACTIONAL_BITS = DEF_FRACTIONAL_BITS,
  parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
  parameter int GUARD_BITS      = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic                         in_valid_i,
  input  logic                         in_last_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] result_o,
  output logic        [CNT_WIDTH-1:0]  count_o,
  output logic                         sat_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  localparam int ACC_WIDTH = DATA_WIDTH + GUARD_BITS;

  localparam logic signed [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX = ACC_WIDTH'(RES_MAX);
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN = ACC_WIDTH'(RES_MIN);

  function automatic logic is_clamped(input logic signed [ACC_WIDTH-1:0] s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH-1:0] s
  );
    if (s > ACC_MAX) return RES_MAX;
    if (s < ACC_MIN) return RES_MIN;
    return DATA_WIDTH'(s);
  endfunction

  acc_state_e                   state_q;
  logic                         accept;
  logic signed [DATA_WIDTH-1:0] prod_p0;
  logic signed [DATA_WIDTH-1:0] prod_p1;
  logic                         vld_p1;
  logic                         last_p1;
  logic signed [ACC_WIDTH-1:0]  sum_p1;
  logic signed [ACC_WIDTH-1:0]  acc_p2;
  logic                         first_q;
  logic        [CNT_WIDTH-1:0]  beats_q;
  logic        [CNT_WIDTH-1:0]  beats_inc;

  // Ready depends only on registers so upstream never sees a comb path
  // from its own valid.
  assign in_ready_o = (state_q == ACC) && !(vld_p1 && last_p1);
  assign accept     = in_valid_i && in_ready_o;

  // ---- stage p0: combinational multiply ----
  qMult_sc #(
    .FRACTIONAL_BITS (FRACTIONAL_BITS),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_mult (
    .a_i (a_i),
    .b_i (b_i),
    .q_o (prod_p0)
  );

  // ---- stage p1: registered product ----
  // Product-stage control flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= accept;
      last_p1 <= accept && in_last_i;
    end
  end

  // Product data, captured only on a transfer
  always_ff @(posedge clk_i) begin
    if (accept) prod_p1 <= prod_p0;
  end

  // Next accumulator value and saturating beat count
  always_comb begin
    sum_p1    = (first_q ? {ACC_WIDTH{1'b0}} : acc_p2) + ACC_WIDTH'(prod_p1);
    beats_inc = (&beats_q) ? beats_q : beats_q + CNT_WIDTH'(1);
  end

  // ---- stage p2: accumulate, emit result, output handshake ----
  // Accumulator, result registers and ACC/DONE sequencing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ACC;
      acc_p2      <= '0;
      first_q     <= 1'b1;
      beats_q     <= '0;
      result_o    <= '0;
      count_o     <= '0;
      sat_o       <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (vld_p1) begin
            acc_p2  <= sum_p1;
            first_q <= 1'b0;
            beats_q <= beats_inc;
            if (last_p1) begin
              result_o    <= saturate(sum_p1);
              count_o     <= beats_inc;
              sat_o       <= is_clamped(sum_p1);
              out_valid_o <= 1'b1;
              first_q     <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
            beats_q     <= '0;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule
